// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the branch predictor: BHT counter states,
// redirect FSM states, table reset value and the counter update rule.
package branch_predict_ctrl_pkg;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_ctr_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    localparam bht_ctr_e BHT_RESET = BHT_WNT;

    // 2-bit saturating step toward the resolved direction
    function automatic bht_ctr_e bht_next(bht_ctr_e c, logic taken);
        bht_ctr_e n;
        n = c;
        unique case (c)
            BHT_SNT: n = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: n = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  n = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  n = taken ? BHT_ST  : BHT_WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht.sv
// Bimodal branch history table: 2**IDX_W 2-bit counters.
// Ports: async read (rd_idx_i -> rd_ctr_o), sync saturating write
// (wr_en_i, wr_idx_i, wr_taken_i), async active-low reset to WNT.
module branch_history_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_ctr_e         rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int N = 2 ** IDX_W;

    bht_ctr_e tbl_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                tbl_q[i] <= BHT_RESET;
            end
        end else if (wr_en_i) begin
            tbl_q[wr_idx_i] <= bht_next(tbl_q[wr_idx_i], wr_taken_i);
        end
    end

    // Read sees the pre-update value when indices collide
    assign rd_ctr_o = tbl_q[rd_idx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor + mispredict recovery: BHT lookup for IF, EX-stage
// resolution, one-cycle registered redirect/flush, saturating stats.
// Ports: clk, rst_n, if_pc/pred_taken (fetch), ex_* (resolution),
// redirect/redirect_pc/flush_ifid/flush_idex, branch_cnt/mispred_cnt.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_jalr,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_target,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  rpc_q, rpc_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             resolve;
    logic             mispredict;
    bht_ctr_e         rd_ctr;

    // The instruction in EX during REDIRECT is wrong-path
    assign resolve = ex_valid & ~ex_stall
                   & (ex_branch | ex_jump)
                   & (state_q == ST_IDLE);

    // JALR targets are never predicted, so it always redirects
    assign mispredict = resolve
                      & ((ex_taken ^ ex_pred_taken) | ex_jalr);

    branch_history_table #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (if_pc[IDX_W+1:2]),
        .rd_ctr_o   (rd_ctr),
        .wr_en_i    (resolve & ex_branch),
        .wr_idx_i   (ex_pc[IDX_W+1:2]),
        .wr_taken_i (ex_taken)
    );

    assign pred_taken = rd_ctr[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (mispredict) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state flop
    always_comb begin
        redirect   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (state_q == ST_REDIRECT) begin
            redirect   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    always_comb begin
        rpc_d = rpc_q;
        if (mispredict) begin
            rpc_d = ex_taken ? ex_target : ex_pc + PC_W'(4);
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (resolve && bcnt_q != '1) begin
            bcnt_d = bcnt_q + CNT_W'(1);
        end
        if (mispredict && mcnt_q != '1) begin
            mcnt_d = mcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpc_q  <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            rpc_q  <= rpc_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign redirect_pc = rpc_q;
    assign branch_cnt  = bcnt_q;
    assign mispred_cnt = mcnt_q;

endmodule
